// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 memory host.
//   host_state_t : host-side job phases
//   HASH_WORDS   : number of 32-bit words in a SHA-256 digest
//   word_t       : 32-bit RAM word
//   addr_t       : 16-bit word address as seen by the engine
package sha256_pkg;

    localparam int unsigned HASH_WORDS = 8;

    typedef logic [31:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        StLoad,
        StKick,
        StRun,
        StDrd,
        StDout
    } host_state_t;

endpackage

// File: rtl/sha256_mem_host_if.sv
// Bundle of host stream, status and engine memory-port signals of sha256_mem_host.
//   slave  : the memory host side (drives in_ready, out_*, status, eng_start, eng read data)
//   master : the system/engine side (drives in_*, out_ready, eng_done, eng_mem_* requests)
interface sha256_mem_host_if;
    import sha256_pkg::*;

    // Message word stream
    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    // Hash word stream
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    logic  out_last;
    // Status
    logic  busy;
    logic  err;
    // Engine control and memory port
    logic  eng_start;
    addr_t eng_message_addr;
    addr_t eng_output_addr;
    logic  eng_done;
    logic  eng_mem_we;
    addr_t eng_mem_addr;
    word_t eng_mem_write_data;
    word_t eng_mem_read_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        input  eng_done, eng_mem_we, eng_mem_addr, eng_mem_write_data,
        output in_ready, out_valid, out_data, out_last, busy, err,
        output eng_start, eng_message_addr, eng_output_addr, eng_mem_read_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        output eng_done, eng_mem_we, eng_mem_addr, eng_mem_write_data,
        input  in_ready, out_valid, out_data, out_last, busy, err,
        input  eng_start, eng_message_addr, eng_output_addr, eng_mem_read_data
    );

endinterface

// File: rtl/sha256_word_ram.sv
// Single-port synchronous word RAM with a registered read port.
//   clk, reset_n : clock; async active-low reset clears only the read register
//   we, addr     : write enable and word address (16-bit, may exceed DEPTH)
//   wdata        : write data
//   rdata        : read register, loaded every cycle from addr (old data on
//                  read-during-write); loads 0 for addresses >= DEPTH
// Writes to addresses >= DEPTH are dropped. RAM contents are never cleared.
module sha256_word_ram
    import sha256_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  we,
    input  addr_t addr,
    input  word_t wdata,
    output word_t rdata
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    word_t           mem [DEPTH];
    word_t           rdata_q, rdata_d;
    logic            in_range;
    logic [IdxW-1:0] idx;

    assign in_range = 32'(addr) < DEPTH;
    assign idx      = IdxW'(addr);

    always_comb begin
        rdata_d = '0;
        if (in_range) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset so it maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sha256_mem_host.sv
// Memory-side responder and host front end for the SHA-256 engine.
//   clk, reset_n : single clock (also the engine memory clock), async active-low reset
//   bus (slave)  : message in-stream, hash out-stream, busy/err status, engine
//                  start pulse, constant message/output base addresses and the
//                  engine memory port (we/addr/write data in, registered read data out)
// Loads NUM_OF_WORDS message words at MSG_BASE, pulses eng_start, hands the RAM
// to the engine until it returns to done, then streams the 8 hash words found
// at OUT_BASE.
// Optional checker: define SHA256_MEM_CHECK_EN to enable the sticky err flag
// and the hash write-count assertion; otherwise err is tied to 0.
module sha256_mem_host
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned DEPTH        = 512,
    parameter addr_t       MSG_BASE     = 16'h0000,
    parameter addr_t       OUT_BASE     = 16'h0100
) (
    input logic              clk,
    input logic              reset_n,
    sha256_mem_host_if.slave bus
);

    localparam addr_t      LastWord = addr_t'(NUM_OF_WORDS - 1);
    localparam logic [2:0] LastHash = 3'(HASH_WORDS - 1);

    host_state_t state_q, state_d;
    addr_t       cnt_q, cnt_d;
    logic [2:0]  hcnt_q, hcnt_d;
    logic        seen_busy_q, seen_busy_d;

    logic  ram_we;
    addr_t ram_addr;
    word_t ram_wdata;
    word_t ram_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        seen_busy_d = seen_busy_q;
        unique case (state_q)
            StLoad: begin
                if (bus.in_valid) begin
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        state_d = StKick;
                    end else begin
                        cnt_d = cnt_q + addr_t'(1);
                    end
                end
            end
            StKick: state_d = StRun;
            StRun: begin
                // eng_done may still be high from the previous idle period;
                // only a rise after a low counts as completion.
                if (seen_busy_q && bus.eng_done) begin
                    seen_busy_d = 1'b0;
                    hcnt_d      = '0;
                    state_d     = StDrd;
                end else if (!bus.eng_done) begin
                    seen_busy_d = 1'b1;
                end
            end
            StDrd: state_d = StDout;
            StDout: begin
                if (bus.out_ready) begin
                    if (hcnt_q == LastHash) begin
                        state_d = StLoad;
                    end else begin
                        hcnt_d  = hcnt_q + 3'd1;
                        state_d = StDrd;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // RAM port owner: engine in RUN, host otherwise; KICK leaves it idle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = MSG_BASE;
        ram_wdata = bus.in_data;
        unique case (state_q)
            StLoad: begin
                ram_we   = bus.in_valid;
                ram_addr = MSG_BASE + cnt_q;
            end
            StRun: begin
                ram_we    = bus.eng_mem_we;
                ram_addr  = bus.eng_mem_addr;
                ram_wdata = bus.eng_mem_write_data;
            end
            StDrd, StDout: begin
                // Re-reading the same word each DOUT cycle keeps out_data stable.
                ram_addr = OUT_BASE + addr_t'(hcnt_q);
            end
            default: ;
        endcase
    end

    sha256_word_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    assign bus.in_ready          = (state_q == StLoad);
    assign bus.busy              = (state_q != StLoad);
    assign bus.eng_start         = (state_q == StKick);
    assign bus.out_valid         = (state_q == StDout);
    assign bus.out_last          = (state_q == StDout) && (hcnt_q == LastHash);
    assign bus.out_data          = (state_q == StDout) ? ram_rdata : '0;
    assign bus.eng_mem_read_data = ram_rdata;
    assign bus.eng_message_addr  = MSG_BASE;
    assign bus.eng_output_addr   = OUT_BASE;

`ifdef SHA256_MEM_CHECK_EN
    logic       err_q, err_d;
    logic       eng_oob;
    logic       hash_wr;
    logic [3:0] hwr_q, hwr_d;

    assign eng_oob = 32'(bus.eng_mem_addr) >= DEPTH;
    assign hash_wr = (state_q == StRun) && bus.eng_mem_we &&
                     (bus.eng_mem_addr >= OUT_BASE) &&
                     (bus.eng_mem_addr < OUT_BASE + addr_t'(HASH_WORDS));

    // In RUN the presented address is an access even without we.
    always_comb begin
        err_d = err_q;
        if (bus.eng_mem_we && ((state_q != StRun) || eng_oob)) begin
            err_d = 1'b1;
        end
        if ((state_q == StRun) && eng_oob) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        hwr_d = hwr_q;
        if (state_q == StKick) begin
            hwr_d = '0;
        end else if (hash_wr && (hwr_q != 4'hf)) begin
            hwr_d = hwr_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
            hwr_q <= '0;
        end else begin
            err_q <= err_d;
            hwr_q <= hwr_d;
        end
    end

    assign bus.err = err_q;

    hash_write_count_a: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == StRun && state_d == StDrd) |-> (hwr_q == 4'(HASH_WORDS)));
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_mem_host.sv
// Randomised bench for sha256_mem_host with an in-bench job-level model.
module tb_sha256_mem_host;
    import sha256_pkg::*;

    localparam int unsigned N     = 20;
    localparam int unsigned DEPTH = 512;
    localparam addr_t       MSG   = 16'h0000;
    localparam addr_t       OUTB  = 16'h0100;
`ifdef SHA256_MEM_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    sha256_mem_host_if bus ();

    sha256_mem_host #(
        .NUM_OF_WORDS(N),
        .DEPTH       (DEPTH),
        .MSG_BASE    (MSG),
        .OUT_BASE    (OUTB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Job-level model: which phase of a job the block is in, what the RAM
    // holds, and what the engine should read back.
    // ------------------------------------------------------------------
    typedef enum {JobLoad, JobKick, JobEngine, JobFetch, JobPresent} job_phase_t;

    word_t      mem_m [DEPTH];
    word_t      hash_m [8];
    job_phase_t ph = JobLoad;
    int         ld_cnt = 0;
    int         h_idx = 0;
    bit         seen_low = 1'b0;
    bit         rd_pend = 1'b0;
    bit         err_m = 1'b0;
    word_t      rd_exp = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            ph       = JobLoad;
            ld_cnt   = 0;
            h_idx    = 0;
            seen_low = 1'b0;
            rd_pend  = 1'b0;
            err_m    = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, ph == JobLoad);
            chk("busy", bus.busy, ph != JobLoad);
            chk("eng_start", bus.eng_start, ph == JobKick);
            chk("out_valid", bus.out_valid, ph == JobPresent);
            chk("out_last", bus.out_last, (ph == JobPresent) && (h_idx == 7));
            if (ph == JobPresent) begin
                chk("out_data", bus.out_data, hash_m[h_idx]);
            end
            chk("err", bus.err, err_m);
            if (rd_pend && !$isunknown(rd_exp)) begin
                chk("eng_mem_read_data", bus.eng_mem_read_data, rd_exp);
            end

            // Effects of the coming clock edge.
            rd_pend = 1'b0;
            if (ChkEn && bus.eng_mem_we && (ph != JobEngine || bus.eng_mem_addr >= DEPTH)) begin
                err_m = 1'b1;
            end
            if (ChkEn && ph == JobEngine && bus.eng_mem_addr >= DEPTH) begin
                err_m = 1'b1;
            end
            case (ph)
                JobLoad: begin
                    if (bus.in_valid) begin
                        mem_m[int'(MSG) + ld_cnt] = bus.in_data;
                        if (ld_cnt == N - 1) begin
                            ld_cnt = 0;
                            ph     = JobKick;
                        end else begin
                            ld_cnt++;
                        end
                    end
                end
                JobKick: begin
                    seen_low = 1'b0;
                    ph       = JobEngine;
                end
                JobEngine: begin
                    rd_pend = 1'b1;
                    if (bus.eng_mem_addr < DEPTH) begin
                        rd_exp = mem_m[bus.eng_mem_addr];
                        if (bus.eng_mem_we) begin
                            mem_m[bus.eng_mem_addr] = bus.eng_mem_write_data;
                        end
                    end else begin
                        rd_exp = '0;
                    end
                    if (!bus.eng_done) begin
                        seen_low = 1'b1;
                    end else if (seen_low) begin
                        for (int i = 0; i < 8; i++) hash_m[i] = mem_m[int'(OUTB) + i];
                        h_idx = 0;
                        ph    = JobFetch;
                    end
                end
                JobFetch: ph = JobPresent;
                JobPresent: begin
                    if (bus.out_ready) begin
                        if (h_idx == 7) begin
                            ph = JobLoad;
                        end else begin
                            h_idx++;
                            ph = JobFetch;
                        end
                    end
                end
                default: ph = JobLoad;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic load_words(input bit lit);
        int i = 0;
        int cyc = 0;
        while (i < N && cyc < 1000) begin
            @(posedge clk);
            #1;
            bus.in_valid = lit ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.in_data  = lit ? word_t'(i) : word_t'($urandom);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            cyc++;
        end
        chk("words loaded", i, N);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (lit) begin
            chk("in_ready after last word", bus.in_ready, 0);
            chk("eng_start after last word", bus.eng_start, 1);
        end
    endtask

    task automatic engine(input int hold, input bit bad_wr, input bit lit);
        int cyc = 0;
        while (bus.eng_start !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("eng_start seen", bus.eng_start, 1);
        if (bus.eng_start !== 1'b1) return;
        @(posedge clk);
        #1;
        if (lit) chk("eng_start single cycle", bus.eng_start, 0);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.eng_done = 1'b0;
        if (lit) begin
            bus.eng_mem_addr = 16'd3;
            @(posedge clk);
            #1;
            chk("engine read of addr 3", bus.eng_mem_read_data, 32'h3);
        end
        repeat ($urandom_range(1, 4)) begin
            bus.eng_mem_addr = MSG + addr_t'($urandom_range(0, N - 1));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            bus.eng_mem_we         = 1'b1;
            bus.eng_mem_addr       = OUTB + addr_t'(i);
            bus.eng_mem_write_data = lit ? (32'hA0 + word_t'(i)) : word_t'($urandom);
            @(posedge clk);
            #1;
        end
        if (bad_wr) begin
            bus.eng_mem_addr       = 16'd512;
            bus.eng_mem_write_data = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            bus.eng_mem_we   = 1'b0;
            bus.eng_mem_addr = 16'd0;
            @(posedge clk);
            #1;
        end
        bus.eng_mem_we   = 1'b0;
        bus.eng_mem_addr = OUTB + addr_t'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        bus.eng_mem_addr = '0;
        bus.eng_done     = 1'b1;
    endtask

    task automatic drain(input bit bp, input bit lit);
        int    got = 0;
        int    cyc = 0;
        int    lowc = 0;
        word_t words [8];
        bit    lasts [8];
        while (got < 8 && cyc < 1500) begin
            @(posedge clk);
            #1;
            if (bp && got == 2 && lowc < 5) begin
                bus.out_ready = 1'b0;
                if (bus.out_valid) lowc++;
            end else begin
                bus.out_ready = lit ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (lit && bp && got == 2 && bus.out_valid && !bus.out_ready) begin
                chk("backpressure hold data", bus.out_data, 32'hA2);
            end
            if (bus.out_valid && bus.out_ready) begin
                words[got] = bus.out_data;
                lasts[got] = bus.out_last;
                got++;
            end
            cyc++;
        end
        chk("hash words drained", got, 8);
        if (lit && got == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("hash word literal", words[i], 32'hA0 + i);
                chk("out_last literal", lasts[i], i == 7);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        if (lit) begin
            chk("busy after h7", bus.busy, 0);
            chk("in_ready after h7", bus.in_ready, 1);
        end
    endtask

    task automatic run_job(input int hold, input bit bp, input bit bad_wr, input bit lit);
        fork
            load_words(lit);
            engine(hold, bad_wr, lit);
            drain(bp, lit);
        join
    endtask

    initial begin
        bus.in_valid           = 1'b0;
        bus.in_data            = '0;
        bus.out_ready          = 1'b0;
        bus.eng_done           = 1'b1;
        bus.eng_mem_we         = 1'b0;
        bus.eng_mem_addr       = '0;
        bus.eng_mem_write_data = '0;

        #1 reset_n = 1'b0;
        #1;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_last", bus.out_last, 0);
        chk("reset eng_start", bus.eng_start, 0);
        chk("reset err", bus.err, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset eng_mem_read_data", bus.eng_mem_read_data, 0);
        chk("eng_message_addr", bus.eng_message_addr, 32'h0000);
        chk("eng_output_addr", bus.eng_output_addr, 32'h0100);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Directed job: 0..0x13 in, A0..A7 out, done held 3 cycles, backpressure on word 2.
        run_job(3, 1'b1, 1'b0, 1'b1);

        // Out-of-range engine write.
        run_job($urandom_range(0, 3), 1'b0, 1'b1, 1'b0);
        chk("err after write to 512", bus.err, ChkEn);

        // Reset in the middle of RUN.
        fork
            load_words(1'b0);
            begin
                int cyc = 0;
                while (bus.eng_start !== 1'b1 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                end
                @(posedge clk);
                #1 bus.eng_done = 1'b0;
                repeat (3) @(posedge clk);
                #3 reset_n = 1'b0;
                #1;
                chk("mid-run reset out_valid", bus.out_valid, 0);
                chk("mid-run reset eng_start", bus.eng_start, 0);
                chk("mid-run reset in_ready", bus.in_ready, 1);
                chk("mid-run reset busy", bus.busy, 0);
                chk("mid-run reset err", bus.err, 0);
                bus.eng_done = 1'b1;
                @(negedge clk);
                @(posedge clk);
                #2 reset_n = 1'b1;
            end
        join

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
